// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: registered fetch port plus a byte-wide valid/ready loader.
// Optional build macro INSTR_MEM_BOUND_CHECK_EN returns DEFAULT_WORD for fetches beyond the array depth.
module instr_mem_loadable #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  input  logic                  iLoadStart,
  input  logic                  iLoadEnd,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadValid,
  output logic                  oLoadReady,
  output logic                  oBusy,
  output logic                  oLoadDone,
  output logic                  oLoadError,
  output logic [ADDR_WIDTH:0]   oLoadWordCount
);

  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]          LAST_BYTE  = 3'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t                  state;
  logic [2:0]              byte_idx;
  logic [DATA_WIDTH-1:0]   word_asm;
  logic [ADDR_WIDTH:0]     count_next;
  logic                    addr_ok;

  // NOTE: the array is preloaded once at configuration and never reset; a
  // reset port on a memory prevents block-RAM inference and would wipe a program.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};

  assign count_next = oLoadWordCount + COUNT_ONE;

`ifdef INSTR_MEM_BOUND_CHECK_EN
  assign addr_ok = (iAddress >> ADDR_WIDTH) == 16'd0;
`else
  // Upper address bits are intentionally ignored so fetches wrap modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^iAddress;
  assign addr_ok        = 1'b1;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      oLoadReady     <= 1'b0;
      oBusy          <= 1'b0;
      oLoadDone      <= 1'b0;
      oLoadError     <= 1'b0;
      oLoadWordCount <= '0;
      byte_idx       <= '0;
      word_asm       <= '0;
    end else begin
      oLoadDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iLoadStart) begin
            state          <= LOAD;
            oLoadReady     <= 1'b1;
            oBusy          <= 1'b1;
            oLoadWordCount <= '0;
            byte_idx       <= '0;
            oLoadError     <= 1'b0;
          end
        end
        LOAD: begin
          // End wins over a byte offered in the same cycle.
          if (iLoadEnd) begin
            state      <= DONE;
            oLoadReady <= 1'b0;
            oBusy      <= 1'b0;
            oLoadDone  <= 1'b1;
            if (byte_idx != 3'd0) oLoadError <= 1'b1;
          end else if (iLoadValid && oLoadReady) begin
            // MSB first; bits of the first byte above DATA_WIDTH fall off the top.
            word_asm <= DATA_WIDTH'({word_asm, iLoadByte});
            if (byte_idx == LAST_BYTE) begin
              byte_idx   <= '0;
              state      <= WRITE;
              oLoadReady <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        WRITE: begin
          oLoadWordCount <= count_next;
          if (count_next == FULL_COUNT) begin
            state     <= DONE;
            oBusy     <= 1'b0;
            oLoadDone <= 1'b1;
          end else begin
            state      <= LOAD;
            oLoadReady <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          oLoadReady <= 1'b0;
          oBusy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (state == WRITE) mem[oLoadWordCount[ADDR_WIDTH-1:0]] <= word_asm;
  end

  // The fetch port is blanked for the whole load so the CPU never sees a half-written program.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oInstruction <= DEFAULT_WORD;
    end else if (oBusy || !addr_ok) begin
      oInstruction <= DEFAULT_WORD;
    end else begin
      oInstruction <= mem[iAddress[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a default-size instance and a 4-word instance
// exercising load, partial-word error, auto-termination, reset mid-load and address range handling.
module tb_instr_mem_loadable;

  localparam logic [27:0] DEF = 28'h00000AA;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] a_addr, b_addr;
  logic        a_start, a_end, a_valid, b_start, b_end, b_valid;
  logic [7:0]  a_byte, b_byte;
  logic [27:0] a_instr, b_instr;
  logic        a_ready, a_busy, a_done, a_err;
  logic        b_ready, b_busy, b_done, b_err;
  logic [8:0]  a_wcount;
  logic [2:0]  b_wcount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [27:0] exp;
  } fetch_vec_t;

  fetch_vec_t vecs [6];

  instr_mem_loadable dut_a (
    .Clock(clk), .Reset(rst), .iAddress(a_addr), .oInstruction(a_instr),
    .iLoadStart(a_start), .iLoadEnd(a_end), .iLoadByte(a_byte), .iLoadValid(a_valid),
    .oLoadReady(a_ready), .oBusy(a_busy), .oLoadDone(a_done), .oLoadError(a_err),
    .oLoadWordCount(a_wcount)
  );

  instr_mem_loadable #(.ADDR_WIDTH(2)) dut_b (
    .Clock(clk), .Reset(rst), .iAddress(b_addr), .oInstruction(b_instr),
    .iLoadStart(b_start), .iLoadEnd(b_end), .iLoadByte(b_byte), .iLoadValid(b_valid),
    .oLoadReady(b_ready), .oBusy(b_busy), .oLoadDone(b_done), .oLoadError(b_err),
    .oLoadWordCount(b_wcount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit to_b, input logic [7:0] v);
    if (to_b) begin
      b_byte = v; b_valid = 1'b1;
    end else begin
      a_byte = v; a_valid = 1'b1;
    end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Four bytes MSB first, then one idle cycle for the WRITE state.
  task automatic send_word(input bit to_b, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(to_b, w[31-8*i -: 8]);
    tick();
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) b_start = 1'b1; else a_start = 1'b1;
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_addr = 16'd5; a_start = 0; a_end = 0; a_valid = 0; a_byte = 0;
    b_addr = 16'd0; b_start = 0; b_end = 0; b_valid = 0; b_byte = 0;

    vecs[0] = '{"fetch0", 16'h0000, 28'h1234567};
    vecs[1] = '{"fetch1", 16'h0001, 28'hABCDEF0};
    vecs[2] = '{"fetch2_unloaded", 16'h0002, DEF};
    vecs[3] = '{"fetch255_unloaded", 16'h00FF, DEF};
`ifdef INSTR_MEM_BOUND_CHECK_EN
    vecs[4] = '{"fetch_0100_range", 16'h0100, DEF};
    vecs[5] = '{"fetch_FF01_range", 16'hFF01, DEF};
`else
    vecs[4] = '{"fetch_0100_wrap", 16'h0100, 28'h1234567};
    vecs[5] = '{"fetch_FF01_wrap", 16'hFF01, 28'hABCDEF0};
`endif

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_instr", a_instr, DEF);
    check("rst_ready", a_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_wcount", a_wcount, 0);
    check("rst_b_wcount", b_wcount, 0);

    // Reset mid-load after 6 bytes
    pulse_start(0);
    check("start_ready", a_ready, 1);
    check("start_busy", a_busy, 1);
    send_word(0, 32'h01234567);
    check("midload_wcount", a_wcount, 1);
    send_byte(0, 8'h0A);
    send_byte(0, 8'hBC);
    rst = 1'b1;
    #1;
    check("async_rst_busy", a_busy, 0);
    check("async_rst_instr", a_instr, DEF);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_ready", a_ready, 0);
    check("postrst_wcount", a_wcount, 0);
    check("postrst_err", a_err, 0);
    a_addr = 16'd0; tick();
    check("postrst_mem0", a_instr, 28'h1234567);
    a_addr = 16'd1; tick();
    check("postrst_mem1", a_instr, DEF);

    // Full two-word load
    a_addr = 16'd0;
    pulse_start(0);
    send_word(0, 32'h01234567);
    check("busy_blank", a_instr, DEF);
    check("word0_ready", a_ready, 1);
    send_word(0, 32'h0ABCDEF0);
    check("load_wcount", a_wcount, 2);
    a_end = 1'b1; a_valid = 1'b1; a_byte = 8'hFF;
    tick();
    a_end = 1'b0; a_valid = 1'b0;
    check("end_done", a_done, 1);
    check("end_busy", a_busy, 0);
    check("end_ready", a_ready, 0);
    check("end_err", a_err, 0);
    check("end_wcount", a_wcount, 2);
    a_addr = 16'd1;
    tick();
    check("done_pulse_once", a_done, 0);
    check("fetch_after_done", a_instr, 28'hABCDEF0);
    check("wcount_hold", a_wcount, 2);

    for (int i = 0; i < 6; i++) begin
      a_addr = vecs[i].addr;
      tick();
      check(vecs[i].name, a_instr, vecs[i].exp);
    end

    // Partial word on the full-size instance
    pulse_start(0);
    send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
    a_end = 1'b1; tick(); a_end = 1'b0;
    check("partial_err", a_err, 1);
    check("partial_done", a_done, 1);
    check("partial_wcount", a_wcount, 0);
    a_addr = 16'd0; tick();
    check("partial_mem0_kept", a_instr, 28'h1234567);
    check("err_sticky", a_err, 1);
    pulse_start(0);
    check("err_cleared_on_start", a_err, 0);
    a_end = 1'b1; tick(); a_end = 1'b0;
    tick();

    // Partial word on the 4-word instance: mem[0] stays at DEFAULT_WORD
    pulse_start(1);
    send_byte(1, 8'h44); send_byte(1, 8'h55); send_byte(1, 8'h66);
    b_end = 1'b1; tick(); b_end = 1'b0;
    check("b_partial_err", b_err, 1);
    check("b_partial_wcount", b_wcount, 0);
    b_addr = 16'd0; tick();
    check("b_partial_mem0", b_instr, DEF);

    // Stream five words with no end pulse: only four fit
    pulse_start(1);
    check("b_start_clears_err", b_err, 0);
    for (int k = 0; k < 4; k++)
      send_word(1, {8'(16 + k), 8'(32 + k), 8'(48 + k), 8'(64 + k)});
    check("b_auto_done", b_done, 1);
    check("b_auto_wcount", b_wcount, 4);
    check("b_auto_ready", b_ready, 0);
    check("b_auto_busy", b_busy, 0);
    send_word(1, 32'h15253545);
    check("b_fifth_wcount", b_wcount, 4);
    check("b_fifth_ready", b_ready, 0);
    b_addr = 16'd3; tick();
    check("b_mem3", b_instr, 28'h3233343);
    b_addr = 16'd0; tick();
    check("b_mem0_not_overwritten", b_instr, 28'h0203040);
    b_addr = 16'h0103; tick();
`ifdef INSTR_MEM_BOUND_CHECK_EN
    check("b_fetch_0103", b_instr, DEF);
`else
    check("b_fetch_0103", b_instr, 28'h3233343);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
